// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution scheduler.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_OUTPUT  = 2'd3
    } conv_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of valid output points for a full-overlap convolution.
    function automatic int y_len(input int x_len, input int f_len);
        return x_len - f_len + 1;
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Handshake and memory-control bundle between a data source/sink and conv_sched.
interface conv_sched_if
    import conv_pkg::*;
#(
    parameter int X_LEN = 112,
    parameter int F_LEN = 49
);
    logic                     x_valid;
    logic                     x_ready;
    logic                     f_valid;
    logic                     f_ready;
    logic                     y_valid;
    logic                     y_ready;
    logic                     wr_en_x;
    logic                     wr_en_f;
    logic [addr_w(X_LEN)-1:0] addr_x;
    logic [addr_w(F_LEN)-1:0] addr_f;
    logic                     clear_acc;
    logic                     en_acc;

    // Master is the environment: it offers samples and consumes results.
    modport master (
        output x_valid, f_valid, y_ready,
        input  x_ready, f_ready, y_valid, wr_en_x, wr_en_f,
               addr_x, addr_f, clear_acc, en_acc
    );

    modport slave (
        input  x_valid, f_valid, y_ready,
        output x_ready, f_ready, y_valid, wr_en_x, wr_en_f,
               addr_x, addr_f, clear_acc, en_acc
    );
endinterface

// File: rtl/conv_cnt.sv
// Modulo-MOD up-counter with synchronous clear and enable; wraps MOD-1 -> 0.
module conv_cnt #(
    parameter int MOD = 2,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_at_top;

    assign w_at_top = (r_cnt == W'(MOD - 1));
    assign o_cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_top ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Address/control sequencer for a 1-D valid convolution over external x/f memories and a MAC.
module conv_sched
    import conv_pkg::*;
#(
    parameter int X_LEN   = 112,
    parameter int F_LEN   = 49,
    parameter int MAC_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic                     f_valid,
    output logic                     f_ready,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     wr_en_x,
    output logic                     wr_en_f,
    output logic [addr_w(X_LEN)-1:0] addr_x,
    output logic [addr_w(F_LEN)-1:0] addr_f,
    output logic                     clear_acc,
    output logic                     en_acc
);

    localparam int Y_LEN = y_len(X_LEN, F_LEN);
    localparam int AXW   = addr_w(X_LEN);
    localparam int AFW   = addr_w(F_LEN);
    localparam int XCW   = addr_w(X_LEN + 1);
    localparam int FCW   = addr_w(F_LEN + 1);
    localparam int JW    = addr_w(Y_LEN);
    localparam int KW    = addr_w(F_LEN);
    localparam int WW    = addr_w(MAC_LAT);

    conv_state_e    r_state;
    conv_state_e    w_state_next;
    logic           r_en_acc;

    logic [XCW-1:0] w_x_cnt;
    logic [FCW-1:0] w_f_cnt;
    logic [JW-1:0]  w_j;
    logic [KW-1:0]  w_k;
    logic [WW-1:0]  w_wait_cnt;

    logic           w_x_full;
    logic           w_f_full;
    logic           w_k_last;
    logic           w_j_last;
    logic           w_wait_last;
    logic           w_y_hs;
    logic           w_run_done;
    logic           w_in_compute;
    logic           w_in_wait;

    assign w_x_full     = (w_x_cnt == XCW'(X_LEN));
    assign w_f_full     = (w_f_cnt == FCW'(F_LEN));
    assign w_k_last     = (w_k == KW'(F_LEN - 1));
    assign w_j_last     = (w_j == JW'(Y_LEN - 1));
    assign w_wait_last  = (w_wait_cnt == WW'(MAC_LAT - 1));
    assign w_in_compute = (r_state == ST_COMPUTE);
    assign w_in_wait    = (r_state == ST_WAIT);

    assign wr_en_x    = x_valid && x_ready;
    assign wr_en_f    = f_valid && f_ready;
    assign w_y_hs     = y_valid && y_ready;
    assign w_run_done = w_y_hs && w_j_last;

    // Load counters run one past the last address so "full" is a plain compare.
    conv_cnt #(.MOD(X_LEN + 1), .W(XCW)) u_x_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_run_done),
        .i_en  (wr_en_x),
        .o_cnt (w_x_cnt)
    );

    conv_cnt #(.MOD(F_LEN + 1), .W(FCW)) u_f_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_run_done),
        .i_en  (wr_en_f),
        .o_cnt (w_f_cnt)
    );

    conv_cnt #(.MOD(Y_LEN), .W(JW)) u_j_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_run_done),
        .i_en  (w_y_hs),
        .o_cnt (w_j)
    );

    // k wraps to 0 on its last tap, so it is already 0 for WAIT, OUTPUT and the next point.
    conv_cnt #(.MOD(F_LEN), .W(KW)) u_k_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (1'b0),
        .i_en  (w_in_compute),
        .o_cnt (w_k)
    );

    conv_cnt #(.MOD(MAC_LAT), .W(WW)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (1'b0),
        .i_en  (w_in_wait),
        .o_cnt (w_wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read data returns one cycle after the address, so en_acc trails COMPUTE by one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en_acc <= 1'b0;
        end else begin
            r_en_acc <= w_in_compute;
        end
    end

    assign en_acc = r_en_acc;

    always_comb begin
        w_state_next = r_state;
        x_ready      = 1'b0;
        f_ready      = 1'b0;
        y_valid      = 1'b0;
        clear_acc    = 1'b0;
        addr_x       = AXW'(w_j) + AXW'(w_k);
        addr_f       = AFW'(w_k);
        case (r_state)
            ST_LOAD: begin
                x_ready = !w_x_full;
                f_ready = !w_f_full;
                addr_x  = AXW'(w_x_cnt);
                addr_f  = AFW'(w_f_cnt);
                if (w_x_full && w_f_full) begin
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                clear_acc = (w_k == '0);
                if (w_k_last) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    w_state_next = w_j_last ? ST_LOAD : ST_COMPUTE;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench: external x/f memories and MAC model, scoreboard of expected points.
module tb_conv_sched;

    localparam int X_LEN   = 112;
    localparam int F_LEN   = 49;
    localparam int MAC_LAT = 3;
    localparam int Y_LEN   = X_LEN - F_LEN + 1;

    logic clk;
    logic rst_n;

    conv_sched_if #(.X_LEN(X_LEN), .F_LEN(F_LEN)) bus ();

    conv_sched #(.X_LEN(X_LEN), .F_LEN(F_LEN), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .x_valid   (bus.x_valid),
        .x_ready   (bus.x_ready),
        .f_valid   (bus.f_valid),
        .f_ready   (bus.f_ready),
        .y_valid   (bus.y_valid),
        .y_ready   (bus.y_ready),
        .wr_en_x   (bus.wr_en_x),
        .wr_en_f   (bus.wr_en_f),
        .addr_x    (bus.addr_x),
        .addr_f    (bus.addr_f),
        .clear_acc (bus.clear_acc),
        .en_acc    (bus.en_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int xs [X_LEN];
    int fs [F_LEN];
    int exp_q [$];
    int xmem [0:127];
    int fmem [0:63];
    int xd, fd, acc;
    logic clr_d;
    int nx, nf, wrx_cnt, wrx_bad, y_cnt;

    typedef struct {
        logic xv;
        logic fv;
        logic wrx;
        logic wrf;
        int   ax;
        int   af;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_plan();
        int s;
        for (int i = 0; i < X_LEN; i++) xs[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < F_LEN; i++) fs[i] = int'($urandom_range(0, 255));
        exp_q.delete();
        for (int j = 0; j < Y_LEN; j++) begin
            s = 0;
            for (int k = 0; k < F_LEN; k++) s += xs[j + k] * fs[k];
            exp_q.push_back(s);
        end
    endtask

    // Source counters, synchronous memories and the MAC datapath.
    always @(posedge clk) begin
        if (bus.wr_en_x) xmem[bus.addr_x] <= xs[(nx < X_LEN) ? nx : 0];
        if (bus.wr_en_f) fmem[bus.addr_f] <= fs[(nf < F_LEN) ? nf : 0];
        xd    <= xmem[bus.addr_x];
        fd    <= fmem[bus.addr_f];
        clr_d <= bus.clear_acc;
        if (bus.en_acc) acc <= (clr_d ? 0 : acc) + xd * fd;
        if (!rst_n) begin
            nx <= 0;
            nf <= 0;
        end else begin
            if (bus.x_valid && bus.x_ready) nx <= nx + 1;
            if (bus.f_valid && bus.f_ready) nf <= nf + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            wrx_cnt <= 0;
            wrx_bad <= 0;
        end else if (bus.wr_en_x) begin
            if (32'(bus.addr_x) != wrx_cnt) wrx_bad <= wrx_bad + 1;
            wrx_cnt <= wrx_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            y_cnt <= 0;
        end else if (bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) check("sb_extra_point", exp_q.size(), 1);
            else check($sformatf("y_point%0d", y_cnt), acc, exp_q.pop_front());
            y_cnt <= y_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int t;
        int bad;
        rst_n       = 1'b0;
        bus.x_valid = 1'b0;
        bus.f_valid = 1'b0;
        bus.y_ready = 1'b0;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 2};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 3};

        // ---------- run 1: gapped load, stall, full 64-point run ----------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_x_ready", bus.x_ready, 1);
        check("rst_f_ready", bus.f_ready, 1);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_en_acc", bus.en_acc, 0);
        check("rst_clear_acc", bus.clear_acc, 0);
        check("rst_wr_en_x", bus.wr_en_x, 0);
        check("rst_wr_en_f", bus.wr_en_f, 0);
        check("rst_addr_x", bus.addr_x, 0);
        check("rst_addr_f", bus.addr_f, 0);

        load_plan();
        bus.y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.x_valid = vecs[i].xv;
            bus.f_valid = vecs[i].fv;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {bus.wr_en_x, bus.wr_en_f, bus.x_ready, bus.f_ready, bus.addr_x, bus.addr_f},
                  {vecs[i].wrx, vecs[i].wrf, 2'b11, 7'(vecs[i].ax), 6'(vecs[i].af)});
        end

        g = 0;
        while ((nx < X_LEN || nf < F_LEN) && g < 3000) begin
            step();
            bus.x_valid = ($urandom_range(0, 1) == 1);
            bus.f_valid = 1'b1;
            g++;
        end
        check("load_in_time", (g < 3000), 1);
        repeat (5) begin
            step();
            bus.x_valid = 1'b1;
            bus.f_valid = 1'b1;
        end
        step();
        bus.x_valid = 1'b0;
        bus.f_valid = 1'b0;
        @(negedge clk);
        check("wr_x_pulses", wrx_cnt, X_LEN);
        check("wr_x_addr_errs", wrx_bad, 0);
        check("x_accepted", nx, X_LEN);
        check("f_accepted", nf, F_LEN);

        g = 0;
        while (y_cnt < 5 && g < 2000) begin @(negedge clk); g++; end
        check("reach_point5", (g < 2000), 1);
        step();
        bus.y_ready = 1'b0;
        g = 0;
        while (!bus.y_valid && g < 200) begin @(negedge clk); g++; end
        check("point5_valid", (g < 200), 1);
        for (int s = 0; s < 10; s++) begin
            if (s > 0) @(negedge clk);
            check($sformatf("stall_c%0d", s),
                  {bus.y_valid, bus.en_acc, bus.addr_x, bus.addr_f},
                  {1'b1, 1'b0, 7'd5, 6'd0});
        end
        step();
        bus.y_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("resume_addr_x", bus.addr_x, 6);
        check("resume_addr_f", bus.addr_f, 0);
        check("resume_clear", bus.clear_acc, 1);

        g = 0;
        while (!(y_cnt == Y_LEN - 1 && bus.clear_acc) && g < 5000) begin @(negedge clk); g++; end
        check("reach_last_point", (g < 5000), 1);
        repeat (F_LEN - 1) @(negedge clk);
        check("last_addr_x", bus.addr_x, X_LEN - 1);
        check("last_addr_f", bus.addr_f, F_LEN - 1);
        g = 0;
        while (y_cnt < Y_LEN && g < 200) begin @(negedge clk); g++; end
        @(negedge clk);
        check("done_x_ready", bus.x_ready, 1);
        check("done_f_ready", bus.f_ready, 1);
        check("done_y_valid", bus.y_valid, 0);
        check("done_points", y_cnt, Y_LEN);
        check("done_queue_left", exp_q.size(), 0);

        // ---------- run 2: back-to-back load, latency, reset mid-COMPUTE ----------
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        load_plan();
        bus.x_valid = 1'b1;
        bus.f_valid = 1'b1;
        bus.y_ready = 1'b1;
        bad = 0;
        for (int c = 0; c <= X_LEN + 1; c++) begin
            @(negedge clk);
            if (bus.x_ready !== (c < X_LEN) || bus.f_ready !== (c < F_LEN)) bad++;
            if (c == F_LEN) check("f_ready_drop", bus.f_ready, 0);
            if (c == X_LEN) begin
                check("x_ready_drop", bus.x_ready, 0);
                check("full_still_load", bus.clear_acc, 0);
            end
            if (c == X_LEN + 1) begin
                check("c0_clear", bus.clear_acc, 1);
                check("c0_addr_x", bus.addr_x, 0);
                check("c0_addr_f", bus.addr_f, 0);
            end
        end
        check("ready_profile", bad, 0);
        step();
        bus.x_valid = 1'b0;
        bus.f_valid = 1'b0;
        t = -1;
        for (int c = X_LEN + 2; c < 400; c++) begin
            @(negedge clk);
            if (bus.y_valid) begin
                t = c;
                break;
            end
        end
        check("y_latency", t - (X_LEN + 1), F_LEN + MAC_LAT);
        @(negedge clk);
        check("p1_addr_x", bus.addr_x, 1);
        check("p1_addr_f", bus.addr_f, 0);
        check("p1_clear", bus.clear_acc, 1);

        g = 0;
        while (!(y_cnt == 10 && bus.clear_acc) && g < 2000) begin @(negedge clk); g++; end
        check("reach_point10", (g < 2000), 1);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("p10_k20_addr_f", bus.addr_f, 20);
        check("p10_k20_addr_x", bus.addr_x, 30);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_x_ready", bus.x_ready, 1);
        check("mid_rst_en_acc", bus.en_acc, 0);
        check("mid_rst_y_valid", bus.y_valid, 0);
        check("mid_rst_addr_x", bus.addr_x, 0);
        check("mid_rst_clear", bus.clear_acc, 0);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter X_LEN, default 112, meaning input-vector length.
REQ-002 SHALL have parameter F_LEN, default 49, meaning filter length; F_LEN <= X_LEN.
REQ-003 SHALL have parameter MAC_LAT, default 3, meaning cycles from last en_acc to a valid accumulator result.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port x_valid  in  1  x sample offered.
REQ-007 SHALL have port x_ready  out  1  x sample accepted when x_valid && x_ready.
REQ-008 SHALL have port f_valid  in  1  filter coefficient offered.
REQ-009 SHALL have port f_ready  out  1  coefficient accepted when f_valid && f_ready.
REQ-010 SHALL have port y_valid  out  1  accumulator holds a finished output point.
REQ-011 SHALL have port y_ready  in  1  consumer takes the point when y_valid && y_ready.
REQ-012 SHALL have port wr_en_x  out  1  x memory write enable.
REQ-013 SHALL have port wr_en_f  out  1  f memory write enable.
REQ-014 SHALL have port addr_x  out  clog2(X_LEN)  x memory address.
REQ-015 SHALL have port addr_f  out  clog2(F_LEN)  f memory address.
REQ-016 SHALL have port clear_acc  out  1  clear MAC accumulator.
REQ-017 SHALL have port en_acc  out  1  MAC accumulate enable, aligned to 1-cycle synchronous memory read data.

Function
REQ-018 SHALL implement the states LOAD, COMPUTE, WAIT and OUTPUT; Y_LEN = X_LEN-F_LEN+1.
REQ-019 SHALL, in LOAD, drive x_ready=1 while x_cnt<X_LEN and f_ready=1 while f_cnt<F_LEN, both 0 otherwise.
REQ-020 SHALL drive wr_en_x = x_valid&&x_ready and wr_en_f = f_valid&&f_ready combinationally, with addr_x=x_cnt and addr_f=f_cnt in LOAD; each counter increments only on its own handshake, and x and f loading proceed independently and concurrently.
REQ-021 SHALL go LOAD->COMPUTE on the edge after both counts are full, with j=0 and k=0.
REQ-022 SHALL, in COMPUTE, issue addr_x=j+k and addr_f=k, increment k each cycle, assert clear_acc in the k=0 cycle only, and assert en_acc registered one cycle after each address issue.
REQ-023 SHALL go COMPUTE->WAIT after k=F_LEN-1 is issued, and spend exactly MAC_LAT cycles in WAIT.
REQ-024 SHALL go WAIT->OUTPUT; if the first COMPUTE cycle of a point is T, then y_valid=1 at T+F_LEN+MAC_LAT.
REQ-025 SHALL, in OUTPUT, hold y_valid=1, en_acc=0 and the addresses stable until y_valid&&y_ready.
REQ-026 SHALL, on the OUTPUT handshake, go to COMPUTE with j+1 and k=0 if j<Y_LEN-1, else go to LOAD with all counters cleared.
REQ-027 SHALL drive x_ready=f_ready=0 outside LOAD; x_valid/f_valid outside LOAD or beyond a full count SHALL cause no write.
REQ-028 SHALL give y_ready no effect while y_valid=0.
REQ-029 SHALL keep the largest addr_x issued at X_LEN-1 (j=Y_LEN-1, k=F_LEN-1); the address never wraps.

Reset
REQ-030 SHALL, on a clock edge with reset=0, enter LOAD with x_cnt=f_cnt=j=k=wait_cnt=0 from any state, including mid-COMPUTE or OUTPUT.
REQ-031 SHALL give these values after reset: x_ready=1, f_ready=1, y_valid=0, en_acc=0, clear_acc=0, wr_en_x=wr_en_f=0 (valid low), addr_x=addr_f=0.

Structure
REQ-032 SHALL define the state enum and the derived widths/Y_LEN helper functions in shared package conv_pkg.
REQ-033 SHALL use one sub-module, conv_cnt (a parameterised modulo up-counter with clear/enable), for the x_cnt, f_cnt, j, k and wait counters.

Verification
REQ-034 SHALL cover: reset, then x_valid=1 for 112 cycles and f_valid=1 for 49 -> f_ready drops after the 49th handshake and x_ready after the 112th; the next cycle is COMPUTE with addr_x=0, addr_f=0, clear_acc=1.
REQ-035 SHALL cover: y_ready=1 held -> first y_valid exactly 52 cycles after the first COMPUTE cycle; the cycle after the handshake shows addr_x=1, addr_f=0, clear_acc=1.
REQ-036 SHALL cover: y_ready=0 for 10 cycles at point 5 -> y_valid stays 1, en_acc=0, addresses unchanged; release -> j=6.
REQ-037 SHALL cover: random 50% x_valid gaps plus 5 extra x_valid after full -> exactly 112 wr_en_x pulses at addresses 0..111 and no write from the extras.
REQ-038 SHALL cover: the full 64-point run -> the final point issues addr_x=111, addr_f=48; after the 64th handshake the block is in LOAD with x_ready=f_ready=1.
REQ-039 SHALL cover: reset=0 for one cycle during COMPUTE of point 10, k=20 -> next cycle LOAD, en_acc=0, y_valid=0, addr_x=0.
